// File: rtl/memory_arbiter_if.sv
// Bundles the requester and RAM signals of the instruction/data memory arbiter.
// Latency: none; this file only declares wires.
// Backpressure: the arbiter stalls requesters through iwait/dwait and waits on ram_ready.
interface memory_arbiter_if;
  // instruction requester
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  // data requester
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  // cpu control
  logic        halt;
  logic        halted;
  // ram side
  logic        ram_ready;
  logic [31:0] ramload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;

  // arbiter view
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ram_ready, ramload,
    output iwait, iload, dwait, dload, halted, ramREN, ramWEN, ramaddr, ramstore
  );

  // cpu + ram view
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ram_ready, ramload,
    input  iwait, iload, dwait, dload, halted, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access; data wins unless the starvation guard fires.
// Latency: 2 cycles minimum (arbitrate in IDLE, complete in the grant cycle where ram_ready=1).
// Backpressure: requesters see iwait/dwait until completion; RAM stalls via ram_ready. Optional guard: MEMORY_ARBITER_STARVE_GUARD_EN.
module memory_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  memory_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t state;

  logic        dreq;
  logic        data_done;
  logic        instr_done;
  logic        forced_instr;

  logic        iwait_c;
  logic        dwait_c;
  logic [31:0] iload_c;
  logic [31:0] dload_c;
  logic        ramren_c;
  logic        ramwen_c;
  logic [31:0] ramaddr_c;
  logic [31:0] ramstore_c;

  // the guard counter is 4 bits wide, so the limit must fit in it
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
    $error("memory_arbiter: STARVE_LIMIT must be within 1..15");
  end

  assign dreq       = bus.dREN | bus.dWEN;
  // a completion needs the requester still asking; a withdrawn request never completes
  assign data_done  = (state == DGRANT) & dreq & bus.ram_ready;
  assign instr_done = (state == IGRANT) & bus.iREN & bus.ram_ready;

`ifdef MEMORY_ARBITER_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  // count data completions that happen while a fetch is waiting; saturates at the limit
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_cnt <= 4'd0;
    end else if (!bus.iREN || instr_done) begin
      starve_cnt <= 4'd0;
    end else if (data_done && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // once halting, fetches are no longer served, so the guard must not block data
  assign forced_instr = (starve_cnt == LIMIT) & bus.iREN & ~bus.halt;
`else
  assign forced_instr = 1'b0;
`endif

  // arbitration and grant sequencing
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (dreq && !forced_instr) begin
            state <= DGRANT;
          end else if (bus.iREN && !bus.halt) begin
            state <= IGRANT;
          end else if (bus.halt) begin
            state <= HALTED;
          end
        end
        DGRANT: begin
          if (!dreq || bus.ram_ready) begin
            state <= IDLE;
          end
        end
        IGRANT: begin
          if (!bus.iREN || bus.ram_ready) begin
            state <= IDLE;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // steer the granted requester onto the RAM; everyone else keeps waiting
  always_comb begin
    iwait_c    = bus.iREN;
    dwait_c    = dreq;
    iload_c    = 32'd0;
    dload_c    = 32'd0;
    ramren_c   = 1'b0;
    ramwen_c   = 1'b0;
    ramaddr_c  = 32'd0;
    ramstore_c = 32'd0;
    case (state)
      DGRANT: begin
        if (dreq) begin
          ramaddr_c  = bus.daddr;
          ramstore_c = bus.dstore;
          ramwen_c   = bus.dWEN;
          ramren_c   = bus.dREN & ~bus.dWEN;
          dwait_c    = ~bus.ram_ready;
          dload_c    = bus.ramload;
        end
      end
      IGRANT: begin
        if (bus.iREN) begin
          ramaddr_c = bus.iaddr;
          ramren_c  = 1'b1;
          iwait_c   = ~bus.ram_ready;
          iload_c   = bus.ramload;
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.iwait    = iwait_c;
  assign bus.dwait    = dwait_c;
  assign bus.iload    = iload_c;
  assign bus.dload    = dload_c;
  assign bus.ramREN   = ramren_c;
  assign bus.ramWEN   = ramwen_c;
  assign bus.ramaddr  = ramaddr_c;
  assign bus.ramstore = ramstore_c;
  assign bus.halted   = (state == HALTED);

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a completion scoreboard.
// Latency: expects completion in the grant cycle that sees ram_ready.
// Backpressure: the bench plays the RAM and drives ram_ready per vector.
module tb_memory_arbiter;

  logic CLK;
  logic nRST;

  memory_arbiter_if bus();

  memory_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] dat;
    logic        wen;
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];

  int checks = 0;
  int errors = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] d, input logic w);
    exp_t e;
    e.addr = a;
    e.dat  = d;
    e.wen  = w;
    return e;
  endfunction

  // monitor: every completion the DUT signals must match the oldest expected one
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (nRST === 1'b1) begin
        if (bus.iREN && !bus.iwait) begin
          if (iq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_icompl addr=%h required=none", bus.ramaddr);
          end else begin
            e = iq.pop_front();
            chk("icompl_addr", bus.ramaddr, e.addr);
            chk("icompl_iload", bus.iload, e.dat);
          end
        end
        if ((bus.dREN || bus.dWEN) && !bus.dwait) begin
          if (dq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_dcompl addr=%h required=none", bus.ramaddr);
          end else begin
            e = dq.pop_front();
            chk("dcompl_addr", bus.ramaddr, e.addr);
            chk("dcompl_wen", {31'd0, bus.ramWEN}, {31'd0, e.wen});
            if (e.wen) chk("dcompl_store", bus.ramstore, e.dat);
            else       chk("dcompl_dload", bus.dload, e.dat);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST          = 1'b0;
    bus.iREN      = 1'b0;
    bus.iaddr     = 32'd0;
    bus.dREN      = 1'b0;
    bus.dWEN      = 1'b0;
    bus.daddr     = 32'd0;
    bus.dstore    = 32'd0;
    bus.halt      = 1'b0;
    bus.ram_ready = 1'b0;
    bus.ramload   = 32'd0;
    #2;
    // reset state
    chk("rst_ramREN", {31'd0, bus.ramREN}, 32'd0);
    chk("rst_ramWEN", {31'd0, bus.ramWEN}, 32'd0);
    chk("rst_ramaddr", bus.ramaddr, 32'd0);
    chk("rst_ramstore", bus.ramstore, 32'd0);
    chk("rst_loads", bus.iload | bus.dload, 32'd0);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);
    step();
    step();
    nRST = 1'b1;

    // instruction fetch at 0x40
    step();
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    #1;
    chk("if_idle_iwait", {31'd0, bus.iwait}, 32'd1);
    chk("if_idle_ramREN", {31'd0, bus.ramREN}, 32'd0);
    step();
    chk("if_grant_ramREN", {31'd0, bus.ramREN}, 32'd1);
    chk("if_grant_ramaddr", bus.ramaddr, 32'h40);
    chk("if_grant_iwait", {31'd0, bus.iwait}, 32'd1);
    step();
    bus.ram_ready = 1'b1; bus.ramload = 32'hDEADBEEF;
    iq.push_back(mk(32'h40, 32'hDEADBEEF, 1'b0));
    #1;
    chk("if_done_iwait", {31'd0, bus.iwait}, 32'd0);
    step();
    bus.iREN = 1'b0; bus.ram_ready = 1'b0; bus.ramload = 32'd0;
    #1;
    chk("if_after_ramREN", {31'd0, bus.ramREN}, 32'd0);
    chk("if_after_iload", bus.iload, 32'd0);

    // simultaneous fetch and write: data first
    step();
    bus.iREN = 1'b1; bus.iaddr = 32'h44;
    bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'h12345678;
    step();
    chk("wr_grant_ramWEN", {31'd0, bus.ramWEN}, 32'd1);
    chk("wr_grant_ramREN", {31'd0, bus.ramREN}, 32'd0);
    chk("wr_grant_ramstore", bus.ramstore, 32'h12345678);
    chk("wr_grant_ramaddr", bus.ramaddr, 32'h80);
    chk("wr_grant_iwait", {31'd0, bus.iwait}, 32'd1);
    step();
    bus.ram_ready = 1'b1;
    dq.push_back(mk(32'h80, 32'h12345678, 1'b1));
    step();
    bus.dWEN = 1'b0; bus.ram_ready = 1'b0;
    #1;
    chk("wr_idle_ramWEN", {31'd0, bus.ramWEN}, 32'd0);
    chk("wr_idle_iwait", {31'd0, bus.iwait}, 32'd1);
    step();
    chk("wr_then_if_ramaddr", bus.ramaddr, 32'h44);
    bus.ram_ready = 1'b1; bus.ramload = 32'h0BADF00D;
    iq.push_back(mk(32'h44, 32'h0BADF00D, 1'b0));
    step();
    bus.iREN = 1'b0; bus.ram_ready = 1'b0; bus.ramload = 32'd0;

    // data read withdrawn before ram_ready
    step();
    bus.dREN = 1'b1; bus.daddr = 32'h100;
    step();
    chk("wd_grant_ramREN", {31'd0, bus.ramREN}, 32'd1);
    chk("wd_grant_dwait", {31'd0, bus.dwait}, 32'd1);
    step();
    bus.dREN = 1'b0; bus.ram_ready = 1'b1; bus.ramload = 32'hFFFFFFFF;
    #1;
    chk("wd_drop_ramREN", {31'd0, bus.ramREN}, 32'd0);
    chk("wd_drop_dload", bus.dload, 32'd0);
    step();
    chk("wd_idle_ramREN", {31'd0, bus.ramREN}, 32'd0);
    chk("wd_idle_dload", bus.dload, 32'd0);
    bus.ram_ready = 1'b0; bus.ramload = 32'd0;

    // data read hammering with a fetch waiting
    step();
    bus.dREN = 1'b1; bus.daddr = 32'h200;
    bus.iREN = 1'b1; bus.iaddr = 32'h300;
    bus.ram_ready = 1'b1; bus.ramload = 32'hA5A50000;
`ifdef MEMORY_ARBITER_STARVE_GUARD_EN
    for (int k = 0; k < 5; k++) dq.push_back(mk(32'h200, 32'hA5A50000, 1'b0));
    iq.push_back(mk(32'h300, 32'hA5A50000, 1'b0));
`else
    for (int k = 0; k < 6; k++) dq.push_back(mk(32'h200, 32'hA5A50000, 1'b0));
`endif
    for (int c = 1; c <= 11; c++) begin
      step();
      if (c == 1) chk("st_c1_ramaddr", bus.ramaddr, 32'h200);
      if (c == 9) begin
`ifdef MEMORY_ARBITER_STARVE_GUARD_EN
        chk("st_c9_forced_ramaddr", bus.ramaddr, 32'h300);
        chk("st_c9_forced_iwait", {31'd0, bus.iwait}, 32'd0);
`else
        chk("st_c9_data_ramaddr", bus.ramaddr, 32'h200);
        chk("st_c9_data_iwait", {31'd0, bus.iwait}, 32'd1);
`endif
      end
      if (c == 11) chk("st_c11_ramaddr", bus.ramaddr, 32'h200);
    end
    step();
    bus.dREN = 1'b0; bus.iREN = 1'b0; bus.ram_ready = 1'b0; bus.ramload = 32'd0;

    // halt raised during a fetch
    step();
    bus.iREN = 1'b1; bus.iaddr = 32'h500;
    step();
    bus.halt = 1'b1;
    #1;
    chk("h_grant_ramREN", {31'd0, bus.ramREN}, 32'd1);
    step();
    bus.ram_ready = 1'b1; bus.ramload = 32'hCAFE0001;
    iq.push_back(mk(32'h500, 32'hCAFE0001, 1'b0));
    step();
    bus.ram_ready = 1'b0; bus.ramload = 32'd0;
    #1;
    chk("h_idle_halted", {31'd0, bus.halted}, 32'd0);
    chk("h_idle_iwait", {31'd0, bus.iwait}, 32'd1);
    step();
    chk("h_halted", {31'd0, bus.halted}, 32'd1);
    chk("h_halted_iwait", {31'd0, bus.iwait}, 32'd1);
    chk("h_halted_ramREN", {31'd0, bus.ramREN}, 32'd0);
    bus.dREN = 1'b1; bus.daddr = 32'h510; bus.ram_ready = 1'b1;
    step();
    chk("h_data_dwait", {31'd0, bus.dwait}, 32'd1);
    chk("h_data_ramREN", {31'd0, bus.ramREN}, 32'd0);
    chk("h_still_halted", {31'd0, bus.halted}, 32'd1);

    // reset leaves HALTED
    nRST = 1'b0;
    #1;
    chk("h_rst_halted", {31'd0, bus.halted}, 32'd0);
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.halt = 1'b0; bus.ram_ready = 1'b0;
    step();
    nRST = 1'b1;

    // reset in the middle of a data grant
    step();
    bus.dREN = 1'b1; bus.daddr = 32'h600;
    step();
    chk("r_grant_ramaddr", bus.ramaddr, 32'h600);
    #2;
    nRST = 1'b0;
    #1;
    chk("r_mid_ramREN", {31'd0, bus.ramREN}, 32'd0);
    chk("r_mid_ramaddr", bus.ramaddr, 32'd0);
    chk("r_mid_dload", bus.dload, 32'd0);
    chk("r_mid_dwait", {31'd0, bus.dwait}, 32'd1);
    step();
    nRST = 1'b1; bus.dREN = 1'b0;
    #1;
    chk("r_rel_dwait", {31'd0, bus.dwait}, 32'd0);
    step();
    bus.ram_ready = 1'b1;
    #1;
    chk("r_idle_ramREN", {31'd0, bus.ramREN}, 32'd0);
    step();
    bus.ram_ready = 1'b0; bus.dREN = 1'b1;
    #1;
    chk("r_follow_dwait", {31'd0, bus.dwait}, 32'd1);
    step();
    bus.ram_ready = 1'b1; bus.ramload = 32'h00000077;
    dq.push_back(mk(32'h600, 32'h00000077, 1'b0));
    step();
    bus.dREN = 1'b0; bus.ram_ready = 1'b0; bus.ramload = 32'd0;
    step();
    step();

    chk("iq_drained", iq.size(), 32'd0);
    chk("dq_drained", dq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, consecutive data grants allowed while an instruction request waits (range 1..15).
REQ-002 CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 nRST  input  1  reset, asynchronous, active-low.
REQ-004 iREN  input  1  instruction read request.
REQ-005 iaddr  input  32  instruction word address.
REQ-006 dREN  input  1  data read request.
REQ-007 dWEN  input  1  data write request.
REQ-008 daddr  input  32  data address.
REQ-009 dstore  input  32  data write value.
REQ-010 halt  input  1  CPU halt; stop serving instruction fetches.
REQ-011 ram_ready  input  1  RAM has completed the current access this cycle.
REQ-012 ramload  input  32  RAM read data, valid when ram_ready=1.
REQ-013 iwait, dwait  output  1 each  requester stalled; deasserted only in the completion cycle.
REQ-014 iload, dload  output  32 each  read data to the requesters.
REQ-015 ramREN, ramWEN  output  1 each  RAM read/write strobes.
REQ-016 ramaddr, ramstore  output  32 each  RAM address and write data.
REQ-017 halted  output  1  arbiter quiesced after halt.

Function
REQ-018 FSM states: IDLE, DGRANT, IGRANT, HALTED; state register is the only sequential path besides the starvation counter.
REQ-019 IDLE: if (dREN|dWEN) and not forced-instruction -> DGRANT; else if iREN and not halt -> IGRANT; else if halt -> HALTED; else stay.
REQ-020 DGRANT: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN (write wins if both set); dwait=~ram_ready; dload=ramload.
REQ-021 IGRANT: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0; iwait=~ram_ready; iload=ramload.
REQ-022 Any grant state with ram_ready=1 -> IDLE next cycle; minimum access latency 2 cycles (request in IDLE, completion earliest in the following cycle).
REQ-023 Requester withdraws (its request low) while granted -> IDLE next cycle, RAM strobes deasserted that cycle, no completion signalled.
REQ-024 In IDLE and in the non-granted requester's view, iwait=iREN and dwait=dREN|dWEN; a non-granted requester is never released.
REQ-025 iload/dload SHALL be 0 except in their own grant state; RAM outputs SHALL be 0 in IDLE and HALTED.
REQ-026 halt asserted during IGRANT: access completes normally, then IDLE -> HALTED; halt during DGRANT: data access completes, pending data requests still served before HALTED.
REQ-027 HALTED: absorbing until reset; halted=1; iwait=iREN; data requests still ignored (dwait=dREN|dWEN).
REQ-028 ram_ready while in IDLE or HALTED SHALL be ignored.

Reset
REQ-029 nRST low: state=IDLE, starvation counter=0, halted=0, ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=0, immediately without clock.
REQ-030 Reset mid-access abandons the transaction; no completion is signalled after release.

Configuration
REQ-031 Macro MEMORY_ARBITER_STARVE_GUARD_EN defined: 4-bit counter increments on each completed data access while iREN=1, clears on each instruction completion or iREN=0; when counter=STARVE_LIMIT, next IDLE arbitration picks IGRANT if iREN (forced-instruction), even with a data request pending.
REQ-032 Macro undefined: strict data-over-instruction priority; counter absent; forced-instruction always 0.

Verification
REQ-033 iREN=1, iaddr=0x40, ram_ready high 2nd cycle of IGRANT, ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x40, iwait low one cycle, iload=0xDEADBEEF, back to IDLE.
REQ-034 iREN and dWEN simultaneous, daddr=0x80, dstore=0x12345678 -> DGRANT first, ramWEN=1, ramstore=0x12345678; IGRANT follows after dwait drops.
REQ-035 Guard enabled, STARVE_LIMIT=4, dREN held high with iREN high, ram_ready=1 each grant -> 4 data completions, then one instruction completion, counter cleared.
REQ-036 halt raised during IGRANT -> fetch completes, next states IDLE then HALTED, halted=1, subsequent iREN keeps iwait=1, ramREN=0.
REQ-037 nRST pulsed low during DGRANT with ram_ready=0 -> all outputs zero immediately, state IDLE, dwait follows dREN after release.
REQ-038 dREN dropped in DGRANT before ram_ready -> strobes drop, IDLE next cycle, dload stays 0.
